k12a_io_serial: RTL and testbench
=================================

// Module: k12a_io_serial
// PURPOSE
//  IO-bus responder for the k12a core: answers io_load/io_store cycles issued in STATE_EXEC by in/out.
//  Provides an 8N1 serial transmitter with a small TX FIFO and a receiver with a 1-byte holding register.
//  Raises wake while received data is pending, so a halted core resumes on input.
// PARAMETERS
//  ADDR_DATA      3'h0  IO port number of the data register (inst[2:0])
//  ADDR_STATUS    3'h1  IO port number of the status/control register
//  CLKS_PER_BIT   16    clock cycles per serial bit, >=4
//  TX_DEPTH       4     TX FIFO entries, power of two, >=2
// PORTS
//  clock        in   1  system clock, all state on rising edge
//  reset        in   1  synchronous, active-high
//  io_addr      in   3  IO port number (inst[2:0])
//  io_load      in   1  core reads IO[io_addr] onto data bus this cycle
//  io_store     in   1  core writes data bus into IO[io_addr] this cycle
//  io_wdata     in   8  data bus value during io_store
//  io_rdata     out  8  read data, valid same cycle as io_load
//  io_rdata_en  out  1  high when io_load and io_addr matches ADDR_DATA/ADDR_STATUS (bus drive enable)
//  rx           in   1  serial input, asynchronous, idle high
//  tx           out  1  serial output, idle high
//  wake         out  1  high while rx_valid (to FSM wake input)
// BEHAVIOUR
//  Reset: tx=1, wake=0, io_rdata_en=0, io_rdata=0; FIFO empty, rx_valid/overrun/frame_err=0, both FSMs IDLE.
//  io_rdata/io_rdata_en combinational from io_load,io_addr; io_rdata=0 when not enabled. Side effects commit at
//   the rising edge ending the io_load/io_store cycle. io_load and io_store never both high (core guarantees).
//  Status read: [0] tx_full, [1] tx_idle (FIFO empty and TX FSM IDLE), [2] rx_valid, [3] overrun, [4] frame_err, [7:5]=0.
//  Status write: bit3=1 clears overrun, bit4=1 clears frame_err (write-1-to-clear); other bits ignored.
//  Data write: push io_wdata into TX FIFO; if full, byte dropped, no other effect.
//  Data read: returns rx_buf (stale value if !rx_valid); clears rx_valid at edge.
//  TX FSM IDLE->START->DATA->STOP->IDLE; each state bit lasts CLKS_PER_BIT cycles via down-counter.
//   IDLE: FIFO non-empty -> pop head into shift reg, tx=0 from next cycle. DATA: 8 bits LSB first.
//   STOP: tx=1; at end, if FIFO non-empty go straight to START (back-to-back, no idle gap), else IDLE.
//   Push to empty FIFO in same cycle as IDLE check: byte seen next cycle (1-cycle push-to-start latency min).
//   Push and pop same cycle when full: pop frees slot first? No: push while full is dropped regardless.
//  RX: rx through 2-flop synchroniser (2-cycle latency). FSM IDLE->START->DATA->STOP->IDLE.
//   IDLE: synced rx=0 -> START, counter = CLKS_PER_BIT/2. START at mid-bit: rx=1 -> IDLE (glitch reject), else DATA.
//   DATA: sample every CLKS_PER_BIT at mid-bit, 8 bits LSB first. STOP at mid-bit:
//    rx=1 -> deliver byte; rx=0 -> byte discarded, frame_err=1. Then IDLE (waits for rx high before new start).
//   Deliver: if !rx_valid -> rx_buf=byte, rx_valid=1. If rx_valid and no data read this cycle -> byte dropped,
//    overrun=1. Data read and deliver same cycle -> new byte stored, rx_valid stays 1, no overrun.
//  Flag set and W1C clear same cycle: set wins.
//  wake = rx_valid registered level (no extra delay); deasserts edge after data read.
//  Reset mid-frame: both FSMs abort to IDLE, tx=1 next cycle, FIFO and rx_buf contents lost.
// TESTING (CLKS_PER_BIT=4, TX_DEPTH=4)
//  Store 0xA5 to port 0 -> tx frame 0,1,0,1,0,0,1,0,1,1 each 4 cycles; status bit1 reads 0 then 1 after stop.
//  Store 5 bytes 0x01..0x05 back-to-back -> 0x01 goes to shift reg, 0x02..0x05 fill FIFO, none dropped;
//   6th store while full dropped; frames back-to-back with no idle gap.
//  Drive rx frame 0x3C -> status reads 0x04|tx_idle, wake=1; load port 0 -> io_rdata=0x3C, wake=0 next cycle.
//  Two rx frames 0x11,0x22 without read -> rx_buf=0x11, overrun=1; store 0x08 to port 1 -> overrun=0.
//  rx frame with stop bit 0 -> frame_err=1, rx_valid=0; 1-cycle low glitch on idle rx -> no frame, no flags.
//  Assert reset mid-TX-data-bit -> tx=1 next cycle, status reads 0x02; rdata=0 when io_addr=3'h5.

Source files
------------

// File: rtl/k12a_io_serial.sv
// IO-bus responder for the k12a core: 8N1 serial transmitter with a small TX FIFO,
// receiver with a one-byte holding register, and a wake output while RX data is pending.
module k12a_io_serial #(
  parameter logic [2:0] ADDR_DATA    = 3'h0,
  parameter logic [2:0] ADDR_STATUS  = 3'h1,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         TX_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] io_addr,
  input  logic       io_load,
  input  logic       io_store,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       io_rdata_en,
  input  logic       rx,
  output logic       tx,
  output logic       wake
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} ser_state_e;

  logic data_sel, status_sel, data_rd, data_wr, stat_wr;
  assign data_sel   = (io_addr == ADDR_DATA);
  assign status_sel = (io_addr == ADDR_STATUS);
  assign data_rd    = io_load  & data_sel;
  assign data_wr    = io_store & data_sel;
  assign stat_wr    = io_store & status_sel;

  // TX FIFO
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (count_q == (AW+1)'(TX_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = data_wr & ~fifo_full;
  assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= io_wdata;
  end

  // TX FSM
  ser_state_e    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
    end
    tx_shift_q <= tx_shift_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    tx         = 1'b1;
    case (tx_state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q];
          tx_cnt_d   = CNT_FULL;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        tx = tx_shift_q[0];
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = CNT_FULL;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == '0) begin
          // Chain straight into the next start bit so queued bytes go out with no idle gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_shift_d = fifo_mem[rd_ptr_q];
            tx_cnt_d   = CNT_FULL;
            tx_state_d = ST_START;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // RX synchroniser; rx_prev_q detects the falling edge so a held-low line never retriggers.
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX FSM
  ser_state_e    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          deliver, ferr_set;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
    end
    rx_shift_q <= rx_shift_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    deliver    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (!rx_s2_q && rx_prev_q) begin
          rx_cnt_d   = CNT_HALF;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = CNT_FULL;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = CNT_FULL;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == '0) begin
          deliver    = rx_s2_q;
          ferr_set   = ~rx_s2_q;
          rx_state_d = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // Holding register and sticky flags
  logic [7:0] rx_buf_q, rx_buf_d;
  logic rx_valid_q, rx_valid_d, overrun_q, overrun_d, ferr_q, ferr_d;

  always_comb begin
    rx_buf_d   = rx_buf_q;
    rx_valid_d = rx_valid_q & ~data_rd;
    overrun_d  = overrun_q & ~(stat_wr & io_wdata[3]);
    ferr_d     = (ferr_q & ~(stat_wr & io_wdata[4])) | ferr_set;
    if (deliver) begin
      if (!rx_valid_q || data_rd) begin
        rx_buf_d   = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_buf_q   <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_buf_q   <= rx_buf_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  logic       tx_idle;
  logic [7:0] status;
  assign tx_idle = fifo_empty & (tx_state_q == ST_IDLE);
  assign status  = {3'b000, ferr_q, overrun_q, rx_valid_q, tx_idle, fifo_full};
  assign wake    = rx_valid_q;

  always_comb begin
    io_rdata_en = io_load & (data_sel | status_sel);
    io_rdata    = '0;
    if (io_load && data_sel)        io_rdata = rx_buf_q;
    else if (io_load && status_sel) io_rdata = status;
  end

endmodule

// File: tb/tb_k12a_io_serial.sv
// Scoreboard bench for k12a_io_serial: bus reads and serial TX frames are checked by
// monitors against expectations queued from a behavioural model of the IO port.
module tb_k12a_io_serial;
  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] io_addr = '0;
  logic       io_load = 1'b0;
  logic       io_store = 1'b0;
  logic [7:0] io_wdata = '0;
  logic [7:0] io_rdata;
  logic       io_rdata_en;
  logic       rx = 1'b1;
  logic       tx;
  logic       wake;

  k12a_io_serial #(.ADDR_DATA(3'h0), .ADDR_STATUS(3'h1), .CLKS_PER_BIT(CPB), .TX_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .io_addr(io_addr), .io_load(io_load), .io_store(io_store),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_rdata_en(io_rdata_en),
    .rx(rx), .tx(tx), .wake(wake)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  int         start_cyc[$];

  // Behavioural model of the receive side
  logic [7:0] m_buf = '0;
  bit m_valid = 0, m_ov = 0, m_fe = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic io_write(input logic [2:0] a, input logic [7:0] d);
    io_addr = a; io_wdata = d; io_store = 1'b1;
    tick(1);
    io_store = 1'b0;
  endtask

  task automatic io_read(input logic [2:0] a, input logic [7:0] exp);
    io_addr = a; io_load = 1'b1;
    rd_q.push_back(exp);
    tick(1);
    io_load = 1'b0;
  endtask

  function automatic logic [7:0] rx_status(input bit tx_idle);
    return {3'b000, m_fe, m_ov, m_valid, tx_idle, 1'b0};
  endfunction

  task automatic read_data();
    io_read(3'h0, m_buf);
    m_valid = 0;
    check("wake_after_read", wake, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; tick(CPB);
    end
    rx = stop; tick(CPB);
    rx = 1'b1; tick(4);
    if (!stop) m_fe = 1;
    else if (!m_valid) begin m_buf = b; m_valid = 1; end
    else m_ov = 1;
  endtask

  // Read-data monitor
  always @(negedge clock) begin
    if (io_rdata_en) begin
      if (rd_q.size() == 0) check("rd_unexpected", io_rdata_en, 0);
      else check("rdata", io_rdata, rd_q.pop_front());
    end
  end

  // Serial TX monitor: decodes each frame at mid-bit and compares with the queued byte
  initial begin
    logic tx_last;
    logic [9:0] bits;
    bit abort;
    tx_last = 1'b1;
    forever begin
      @(negedge clock);
      if (tx_last === 1'b1 && tx === 1'b0) begin
        start_cyc.push_back(cyc);
        abort = reset;
        for (int j = 0; j < 10; j++) begin
          repeat (j == 0 ? 1 : CPB) begin
            @(negedge clock);
            if (reset) abort = 1;
          end
          bits[j] = tx;
        end
        if (!abort) begin
          if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
          else begin
            check("tx_byte", bits[8:1], tx_q.pop_front());
            check("tx_start_stop", {bits[9], bits[0]}, 2'b10);
          end
        end
      end
      tx_last = tx;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int n;
    tick(3);
    check("reset_tx", tx, 1);
    check("reset_wake", wake, 0);
    check("reset_rdata_en", io_rdata_en, 0);
    check("reset_rdata", io_rdata, 0);
    reset = 1'b0;
    tick(2);
    io_read(3'h1, 8'h02);

    // Single byte, tx_idle low while busy then high after the stop bit
    tx_q.push_back(8'hA5);
    io_write(3'h0, 8'hA5);
    io_read(3'h1, 8'h00);
    tick(45);
    io_read(3'h1, 8'h02);

    // Back-to-back burst filling the FIFO, sixth byte dropped
    start_cyc.delete();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) tx_q.push_back(8'(i));
      io_write(3'h0, 8'(i));
    end
    io_read(3'h1, 8'h01);
    tick(5 * 40 + 10);
    io_read(3'h1, 8'h02);
    check("burst_frames", start_cyc.size(), 5);
    for (int i = 1; i < start_cyc.size(); i++)
      check("burst_gap", start_cyc[i] - start_cyc[i-1], 10 * CPB);

    // Random TX bursts
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        tx_q.push_back(b);
        io_write(3'h0, b);
      end
      tick(n * 40 + 10);
      io_read(3'h1, 8'h02);
    end

    // RX single frame and wake
    send_rx(8'h3C, 1);
    io_read(3'h1, rx_status(1));
    check("wake_set", wake, 1);
    read_data();

    // Overrun and its write-1-to-clear
    send_rx(8'h11, 1);
    send_rx(8'h22, 1);
    io_read(3'h1, rx_status(1));
    io_write(3'h1, 8'h08);
    m_ov = 0;
    io_read(3'h1, rx_status(1));
    read_data();

    // Framing error, then glitch rejection
    send_rx(8'hAB, 0);
    io_read(3'h1, rx_status(1));
    io_write(3'h1, 8'h10);
    m_fe = 0;
    io_read(3'h1, rx_status(1));
    rx = 1'b0; tick(1); rx = 1'b1; tick(12);
    io_read(3'h1, rx_status(1));
    check("glitch_wake", wake, 0);

    // Random RX traffic against the model
    for (int k = 0; k < 10; k++) begin
      send_rx(8'($urandom), $urandom_range(0, 4) != 0);
      check("rnd_wake", wake, m_valid);
      if ($urandom_range(0, 1) == 1) io_read(3'h1, rx_status(1));
      if ($urandom_range(0, 2) != 0) read_data();
      if ($urandom_range(0, 3) == 0) begin
        io_write(3'h1, 8'h18);
        m_ov = 0; m_fe = 0;
      end
    end
    io_read(3'h1, rx_status(1));

    // Unmapped port: no drive, zero data
    io_addr = 3'h5; io_load = 1'b1;
    @(negedge clock);
    check("unmapped_en", io_rdata_en, 0);
    check("unmapped_rdata", io_rdata, 0);
    tick(1);
    io_load = 1'b0;

    // Reset in the middle of a data bit
    send_rx(8'h77, 1);
    io_write(3'h0, 8'h5A);
    tick(12);
    reset = 1'b1;
    tick(1);
    check("midreset_tx", tx, 1);
    check("midreset_wake", wake, 0);
    reset = 1'b0;
    m_valid = 0; m_ov = 0; m_fe = 0; m_buf = '0;
    io_read(3'h1, 8'h02);
    tick(45);
    io_read(3'h1, 8'h02);
    read_data();

    tick(5);
    check("rd_q_drained", rd_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
